// File: rtl/muxn_reg.sv
// -----------------------------------------------------------------------------
// muxn_reg
//   N-way channel selector with a one-deep registered output stage and
//   valid/ready handshaking on both sides. The chosen channel is captured
//   on accept. An out-of-range select captures zero and raises muxn_sel_err.
//   The beat is still passed downstream.
//
// Optional feature macro: MUXN_REG_ERR_CNT_EN
//   When defined, muxn_err_cnt is a saturating (0..255) count of accepted
//   beats whose select was out of range. It is cleared only by rst.
//   When undefined, muxn_err_cnt is tied to zero and no counter is built.
//
// Parameters
//   D_WIDTH   data width per channel (>= 1)
//   N_IN      number of input channels (2..16)
//   SEL_WIDTH select width, 2**SEL_WIDTH >= N_IN
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous reset, active-high
//   muxn_data       flattened channels, channel k at [k*D_WIDTH +: D_WIDTH]
//   muxn_sel        channel index
//   muxn_in_valid   upstream beat valid
//   muxn_in_ready   block can accept this cycle
//   muxn_result     registered selected data
//   muxn_sel_err    registered out-of-range flag for the held beat
//   muxn_out_valid  muxn_result/muxn_sel_err hold a beat
//   muxn_out_ready  downstream accepts this cycle
//   muxn_err_cnt    saturating out-of-range count (zero when feature off)
// -----------------------------------------------------------------------------
module muxn_reg #(
  parameter int D_WIDTH   = 12,
  parameter int N_IN      = 3,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN*D_WIDTH-1:0]   muxn_data,
  input  logic [SEL_WIDTH-1:0]      muxn_sel,
  input  logic                      muxn_in_valid,
  output logic                      muxn_in_ready,
  output logic [D_WIDTH-1:0]        muxn_result,
  output logic                      muxn_sel_err,
  output logic                      muxn_out_valid,
  input  logic                      muxn_out_ready,
  output logic [7:0]                muxn_err_cnt
);

  // Every encodable select value gets a slot so the lookup below never
  // indexes outside the array. Slots at or above N_IN read as zero and
  // are flagged out of range.
  localparam int NUM_SLOTS = 1 << SEL_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e               state_q;
  logic [D_WIDTH-1:0]   result_q;
  logic [D_WIDTH-1:0]   result_d;
  logic                 sel_err_q;
  logic                 sel_err_d;

  logic [D_WIDTH-1:0]   slot_data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_oob;

  logic                 accept;
  logic                 emit;

  // ---------------------------------------------------------------------------
  // Channel slot table
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < N_IN) begin : g_real
        assign slot_data[gi] = muxn_data[gi*D_WIDTH +: D_WIDTH];
        assign slot_oob[gi]  = 1'b0;
      end else begin : g_pad
        assign slot_data[gi] = '0;
        assign slot_oob[gi]  = 1'b1;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // The register frees up in the same cycle it is drained. That lets the
  // stage run one beat per cycle without a skid buffer. The cost is a
  // combinational path from muxn_out_ready to muxn_in_ready.
  assign muxn_in_ready  = !rst && ((state_q == ST_EMPTY) || muxn_out_ready);
  assign muxn_out_valid = (state_q == ST_FULL);
  assign accept         = muxn_in_valid && muxn_in_ready;
  assign emit           = muxn_out_valid && muxn_out_ready;

  // Padded slots already carry zero data. The data and the flag therefore
  // come straight from the table.
  always_comb begin
    result_d  = slot_data[muxn_sel];
    sel_err_d = slot_oob[muxn_sel];
  end

  // ---------------------------------------------------------------------------
  // Output stage FSM with registered result/flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      result_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (emit && !accept) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      // Held values move only on an accept. In all other cycles they stay
      // stable, whatever happens on the inputs.
      if (accept) begin
        result_q  <= result_d;
        sel_err_q <= sel_err_d;
      end
    end
  end

  assign muxn_result  = result_q;
  assign muxn_sel_err = sel_err_q;

  // ---------------------------------------------------------------------------
  // Out-of-range counter
  // ---------------------------------------------------------------------------
`ifdef MUXN_REG_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && sel_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign muxn_err_cnt = err_cnt_q;
`else
  assign muxn_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_muxn_reg.sv
module tb_muxn_reg;

  // ---------------- main instance: D_WIDTH=12, N_IN=3, SEL_WIDTH=2 ----------
  logic        clk;
  logic        rst;
  logic [35:0] data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] result;
  logic        sel_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;

  // ---------------- sweep instance: D_WIDTH=8, N_IN=5, SEL_WIDTH=3 ----------
  logic [39:0] n5_data;
  logic [2:0]  n5_sel;
  logic        n5_in_valid;
  logic        n5_in_ready;
  logic [7:0]  n5_result;
  logic        n5_sel_err;
  logic        n5_out_valid;
  logic        n5_out_ready;
  logic [7:0]  n5_err_cnt;

  int total = 0;
  int bad   = 0;

  // scoreboard: {sel_err, result}
  logic [12:0] sb_q[$];
  logic        model_valid;
  logic [11:0] last_res;
  logic        last_err;
  int          exp_cnt;
  int          n5_exp_cnt;

  muxn_reg #(.D_WIDTH(12), .N_IN(3), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .muxn_data(data), .muxn_sel(sel),
    .muxn_in_valid(in_valid), .muxn_in_ready(in_ready),
    .muxn_result(result), .muxn_sel_err(sel_err),
    .muxn_out_valid(out_valid), .muxn_out_ready(out_ready),
    .muxn_err_cnt(err_cnt)
  );

  muxn_reg #(.D_WIDTH(8), .N_IN(5), .SEL_WIDTH(3)) dut_n5 (
    .clk(clk), .rst(rst),
    .muxn_data(n5_data), .muxn_sel(n5_sel),
    .muxn_in_valid(n5_in_valid), .muxn_in_ready(n5_in_ready),
    .muxn_result(n5_result), .muxn_sel_err(n5_sel_err),
    .muxn_out_valid(n5_out_valid), .muxn_out_ready(n5_out_ready),
    .muxn_err_cnt(n5_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_select(input logic [35:0] d, input logic [1:0] s);
    logic [35:0] sh;
    if (s >= 2'd3) return 12'h000;
    sh = d >> (s * 12);
    return sh[11:0];
  endfunction

  function automatic int cnt_expect(input int c);
`ifdef MUXN_REG_ERR_CNT_EN
    return c;
`else
    return (c == c) ? 0 : 0;
`endif
  endfunction

  // Inputs are set by the caller just after a falling edge. This checks
  // the outputs, updates the model, and advances to the next falling edge.
  task automatic step();
    logic        exp_ready;
    logic        acc;
    logic        emt;
    logic [12:0] head;
    #1;
    exp_ready = !rst && (!model_valid || out_ready);
    check_value("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check_value("out_valid", {31'd0, out_valid}, {31'd0, model_valid});
    check_value("result", {20'd0, result}, {20'd0, last_res});
    check_value("sel_err", {31'd0, sel_err}, {31'd0, last_err});
    check_value("err_cnt", {24'd0, err_cnt}, cnt_expect(exp_cnt));
    acc = in_valid && exp_ready;
    emt = model_valid && out_ready;
    if (rst) begin
      sb_q.delete();
      model_valid = 1'b0;
      last_res    = 12'h000;
      last_err    = 1'b0;
      exp_cnt     = 0;
    end else begin
      if (emt) begin
        if (sb_q.size() == 0) begin
          check_value("sb_empty", 32'd1, 32'd0);
        end else begin
          head = sb_q.pop_front();
          check_value("emit_data", {19'd0, sel_err, result}, {19'd0, head});
          $display("emit result=%h sel_err=%b err_cnt=%0d", result, sel_err, err_cnt);
        end
      end
      if (acc) begin
        last_res = ref_select(data, sel);
        last_err = (sel >= 2'd3);
        sb_q.push_back({last_err, last_res});
        if (last_err && exp_cnt < 255) exp_cnt++;
      end
      model_valid = acc || (model_valid && !out_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [35:0] BASE = {12'hC03, 12'hB02, 12'hA01};

  initial begin
    logic [2:0] n5_exp_sel;
    rst = 1'b1; data = BASE; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
    n5_data = '0; n5_sel = '0; n5_in_valid = 1'b0; n5_out_ready = 1'b1;
    model_valid = 1'b0; last_res = '0; last_err = 1'b0; exp_cnt = 0; n5_exp_cnt = 0;
    for (int k = 0; k < 5; k++) n5_data[k*8 +: 8] = 8'h10 + 8'(k);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();                              // first cycle after reset: idle

    // basic select, then out-of-range, then streaming 0,1,2,0
    in_valid = 1'b1; sel = 2'd1; step();
    sel = 2'd3; step();
    sel = 2'd0; step();
    sel = 2'd1; step();
    sel = 2'd2; step();
    sel = 2'd0; step();
    in_valid = 1'b0; step(); step();

    // backpressure: hold A01 while inputs churn
    in_valid = 1'b1; sel = 2'd0; data = BASE; step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data = {$urandom, $urandom}; sel = 2'($urandom_range(0, 3)); step();
    end
    out_ready = 1'b1; data = BASE; sel = 2'd2; step();
    in_valid = 1'b0; step(); step();

    // 300 out-of-range beats, counter must saturate
    in_valid = 1'b1; sel = 2'd3;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0; step(); step();

    // reset while holding C03 under backpressure
    in_valid = 1'b1; sel = 2'd2; data = BASE; step();
    in_valid = 1'b0; out_ready = 1'b0; step();
    rst = 1'b1; in_valid = 1'b1; sel = 2'd1; step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();

    // random mix
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      data      = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; step(); step();
    check_value("sb_left", sb_q.size(), 32'd0);

    // parameter sweep on the 5-channel instance
    for (int s = 0; s < 8; s++) begin
      n5_sel = 3'(s); n5_in_valid = 1'b1;
      @(posedge clk);
      #1;
      n5_exp_sel = 3'(s);
      if (s >= 5) n5_exp_cnt++;
      check_value("n5_valid", {31'd0, n5_out_valid}, 32'd1);
      check_value("n5_result", {24'd0, n5_result}, (s < 5) ? 32'h10 + s : 32'h0);
      check_value("n5_sel_err", {31'd0, n5_sel_err}, (n5_exp_sel >= 3'd5) ? 32'd1 : 32'd0);
      check_value("n5_err_cnt", {24'd0, n5_err_cnt}, cnt_expect(n5_exp_cnt));
      $display("n5 sel=%0d result=%h sel_err=%b", s, n5_result, n5_sel_err);
      @(negedge clk);
    end
    n5_in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
